// File: rtl/bsg_wormhole_broadcast_inject_arbiter_pkg.sv
// Shared types for the wormhole broadcast inject arbiter: FSM state encoding
// and the header field offsets of the network's flit format.
package bsg_wormhole_broadcast_arb_pkg;

    typedef enum logic {
        e_idle,
        e_locked
    } state_e;

    // Coordinate occupies the low bits; the length field follows directly above it.
    localparam int cord_offset_lp = 0;

    function automatic int len_offset(input int cord_width);
        return cord_offset_lp + cord_width;
    endfunction

endpackage

// File: rtl/bsg_wormhole_broadcast_inject_arbiter_rr_picker.sv
// Combinational rotate-priority picker: returns the first set request found
// scanning upward from rr_ptr with wrap-around, plus a found flag.
module bsg_wormhole_broadcast_rr_picker #(
    parameter int num_in_p     = 4,
    parameter int ptr_width_lp = $clog2(num_in_p)
) (
    input  logic [num_in_p-1:0]     v,
    input  logic [ptr_width_lp-1:0] rr_ptr,
    output logic [ptr_width_lp-1:0] sel,
    output logic                    found
);

    logic [ptr_width_lp:0]   sum;
    logic [ptr_width_lp-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int k = num_in_p - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ptr_width_lp + 1)'(k);
            if (sum >= (ptr_width_lp + 1)'(num_in_p)) begin
                sum = sum - (ptr_width_lp + 1)'(num_in_p);
            end
            idx = sum[ptr_width_lp-1:0];
            if (v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_broadcast_inject_arbiter.sv
// Packet-granular round-robin arbiter feeding one wormhole broadcast input.
// Optional simulation checks are enabled with BSG_WORMHOLE_BCAST_ARB_ASSERT_EN.
module bsg_wormhole_broadcast_inject_arbiter
    import bsg_wormhole_broadcast_arb_pkg::*;
#(
    parameter int flit_width_p = 16,
    parameter int len_width_p  = 4,
    parameter int cord_width_p = 4,
    parameter int num_in_p     = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_in_p-1:0]                  v_i,
    input  logic [num_in_p-1:0][flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]                  ready_and_o,
    output logic                                 v_o,
    output logic [flit_width_p-1:0]              data_o,
    input  logic                                 ready_and_i
);

    localparam int ptr_width_lp = $clog2(num_in_p);
    localparam int len_lsb_lp   = len_offset(cord_width_p);

    state_e                  state_r;
    logic [ptr_width_lp-1:0] rr_ptr_r;
    logic [ptr_width_lp-1:0] lock_idx_r;
    logic [len_width_p-1:0]  remain_r;

    logic [ptr_width_lp-1:0] pick_sel;
    logic                    pick_found;
    logic [ptr_width_lp-1:0] sel;
    logic                    active;
    logic                    xfer;
    logic [len_width_p-1:0]  hdr_len;

    function automatic logic [ptr_width_lp-1:0] wrap_inc(input logic [ptr_width_lp-1:0] idx);
        return (idx == ptr_width_lp'(num_in_p - 1)) ? '0 : idx + 1'b1;
    endfunction

    bsg_wormhole_broadcast_rr_picker #(
        .num_in_p    (num_in_p),
        .ptr_width_lp(ptr_width_lp)
    ) picker (
        .v     (v_i),
        .rr_ptr(rr_ptr_r),
        .sel   (pick_sel),
        .found (pick_found)
    );

    // The selection is only sticky once a multi-flit header has actually transferred.
    assign sel         = (state_r == e_locked) ? lock_idx_r : pick_sel;
    assign active      = ~reset_i & ((state_r == e_locked) | pick_found);
    assign v_o         = active & v_i[sel];
    assign data_o      = data_i[sel];
    assign ready_and_o = active ? (num_in_p'(ready_and_i) << sel) : '0;
    assign xfer        = v_o & ready_and_i;
    assign hdr_len     = data_i[sel][len_lsb_lp +: len_width_p];

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
        if (reset_i) begin
            state_r    <= e_idle;
            rr_ptr_r   <= '0;
            lock_idx_r <= '0;
            remain_r   <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (xfer) begin
                        if (hdr_len == '0) begin
                            rr_ptr_r <= wrap_inc(sel);
                        end else begin
                            lock_idx_r <= sel;
                            remain_r   <= hdr_len;
                            state_r    <= e_locked;
                        end
                    end
                end
                e_locked: begin
                    if (xfer) begin
                        remain_r <= remain_r - 1'b1;
                        if (remain_r == len_width_p'(1)) begin
                            rr_ptr_r <= wrap_inc(lock_idx_r);
                            state_r  <= e_idle;
                        end
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

`ifdef BSG_WORMHOLE_BCAST_ARB_ASSERT_EN
    for (genvar i = 0; i < num_in_p; i++) begin : g_req_chk
        assert property (@(posedge clk_i) disable iff (reset_i)
            (v_i[i] & ~ready_and_o[i]) |=> $stable(data_i[i]))
            else $error("requester %0d changed its flit while waiting", i);
        assert property (@(posedge clk_i) disable iff (reset_i)
            (v_i[i] & ~ready_and_o[i]) |=> v_i[i])
            else $error("requester %0d dropped valid before the handshake", i);
    end
    assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o & (state_r == e_locked)) |-> (sel == lock_idx_r))
        else $error("output driven by a requester other than the lock holder");
    assert property (@(posedge clk_i) disable iff (reset_i)
        ((state_r == e_locked) & xfer) |-> (remain_r != '0))
        else $error("remaining flit count underflow");
`endif

endmodule

// File: tb/tb_bsg_wormhole_broadcast_inject_arbiter.sv
// Self-checking bench: packet-queue requesters, a behavioural arbitration model,
// directed scenarios with literal grant sequences, then randomized traffic.
module tb_bsg_wormhole_broadcast_inject_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int LW = 4;
    localparam int FW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         v_i;
    logic [N-1:0][FW-1:0] data_i;
    logic [N-1:0]         ready_and_o;
    logic                 v_o;
    logic [FW-1:0]        data_o;
    logic                 ready_and_i;

    bsg_wormhole_broadcast_inject_arbiter #(
        .flit_width_p(FW),
        .len_width_p (LW),
        .cord_width_p(CW),
        .num_in_p    (N)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_and_o(ready_and_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .ready_and_i(ready_and_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester packet queues: flits in order, with a header marker per flit.
    logic [FW-1:0] fq [N][$];
    bit            hq [N][$];
    bit  [N-1:0]   held;
    int            stall_pct;
    bit            rand_ready;
    bit            ready_q [$];

    // Behavioural model: current packet owner (-1 when none), flits left, priority pointer.
    int owner, left, prio;
    int xfer_log [$];
    logic         s_v_o;
    logic [N-1:0] s_rdy;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int i, input int len);
        logic [FW-1:0] h;
        h = FW'($urandom);
        h[CW +: LW] = LW'(len);
        fq[i].push_back(h);
        hq[i].push_back(1'b1);
        for (int b = 0; b < len; b++) begin
            fq[i].push_back(FW'($urandom));
            hq[i].push_back(1'b0);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() > 0) begin
                data_i[i] = fq[i][0];
                v_i[i]    = hq[i][0] || held[i] || ($urandom_range(0, 99) >= stall_pct);
            end else begin
                data_i[i] = FW'($urandom);
                v_i[i]    = 1'b0;
            end
        end
    endtask

    task automatic drive_ready();
        if (ready_q.size() > 0) ready_and_i = ready_q.pop_front();
        else if (rand_ready)    ready_and_i = ($urandom_range(0, 3) != 0);
        else                    ready_and_i = 1'b1;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: compare at the falling edge, advance model and requesters after the rising edge.
    task automatic cycle();
        int           s;
        logic         ev;
        logic [N-1:0] er;
        logic         xfer;
        logic [N-1:0] take;
        int           len;
        @(negedge clk);
        s  = -1;
        ev = 1'b0;
        er = '0;
        if (!reset) begin
            if (owner >= 0) s = owner;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (s < 0 && v_i[(prio + k) % N]) s = (prio + k) % N;
                end
            end
            if (s >= 0) begin
                ev = v_i[s];
                er = ready_and_i ? (N'(1) << s) : '0;
            end
        end
        s_v_o = v_o;
        s_rdy = ready_and_o;
        check("v_o", v_o, ev);
        check("ready_and_o", ready_and_o, er);
        if (ev) check("data_o", data_o, data_i[s]);
        xfer = ev && ready_and_i;
        take = v_i & ready_and_o;
        @(posedge clk);
        if (reset) begin
            owner = -1; left = 0; prio = 0; held = '0;
            for (int i = 0; i < N; i++) begin
                fq[i].delete();
                hq[i].delete();
            end
        end else begin
            if (xfer) begin
                xfer_log.push_back(s);
                if (owner < 0) begin
                    len = int'(data_i[s][CW +: LW]);
                    if (len == 0) prio = (s + 1) % N;
                    else begin
                        owner = s;
                        left  = len;
                    end
                end else begin
                    left--;
                    if (left == 0) begin
                        owner = -1;
                        prio  = (s + 1) % N;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (take[i] && fq[i].size() > 0) begin
                    void'(fq[i].pop_front());
                    void'(hq[i].pop_front());
                end
                held[i] = v_i[i] && !take[i];
            end
        end
        #1;
        drive_ready();
        drive_req();
    endtask

    task automatic drain(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!all_empty() && cycles < budget) begin
            cycle();
            cycles++;
        end
        check({name, "_drained"}, 32'(all_empty()), 1);
    endtask

    task automatic check_log(input string name, input int exp [$]);
        check({name, "_count"}, xfer_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xfer_log.size(); i++) begin
            check({name, "_grant"}, xfer_log[i], exp[i]);
        end
    endtask

    initial begin
        int e [$];
        int n;
        reset = 1'b1; v_i = '0; data_i = '0; ready_and_i = 1'b1;
        owner = -1; left = 0; prio = 0; held = '0;
        stall_pct = 0; rand_ready = 1'b0;

        // Reset, then idle inputs keep the output quiet.
        cycle(); cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("idle_v_o", 32'(s_v_o), 0);
            check("idle_ready", 32'(s_rdy), 0);
        end

        // Two len=2 packets presented together: input 1 first, back-to-back.
        xfer_log.delete();
        push_pkt(1, 2); push_pkt(3, 2); drive_req();
        drain("pair", 50, n);
        check("pair_cycles", n, 6);
        e = '{1, 1, 1, 3, 3, 3};
        check_log("pair", e);

        // All four continuously sending single-flit packets rotate fairly.
        xfer_log.delete();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 0);
        drive_req();
        drain("rotate", 50, n);
        check("rotate_cycles", n, 8);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rotate", e);

        // Network stall mid-packet: input 0 stays blocked until input 2 finishes.
        xfer_log.delete();
        push_pkt(2, 3); drive_req();
        ready_q = '{1'b1, 1'b0, 1'b0};
        cycle();
        push_pkt(0, 0); drive_req();
        drain("stall", 50, n);
        check("stall_cycles", n, 6);
        e = '{2, 2, 2, 2, 0};
        check_log("stall", e);

        // Reset while locked with five body flits still to go.
        push_pkt(1, 8); drive_req();
        for (int c = 0; c < 4; c++) cycle();
        reset = 1'b1;
        cycle();
        check("reset_v_o", 32'(s_v_o), 0);
        check("reset_ready", 32'(s_rdy), 0);
        reset = 1'b0;
        xfer_log.delete();
        push_pkt(1, 0); push_pkt(0, 0); drive_req();
        drain("post_reset", 50, n);
        check("post_reset_cycles", n, 2);
        e = '{0, 1};
        check_log("post_reset", e);

        // Maximum length packet: 16 flits, then the waiting requester.
        xfer_log.delete();
        push_pkt(3, 15); push_pkt(0, 0); drive_req();
        drain("maxlen", 100, n);
        check("maxlen_cycles", n, 17);
        e.delete();
        for (int i = 0; i < 16; i++) e.push_back(3);
        e.push_back(0);
        check_log("maxlen", e);

        // Randomized traffic with requester and network stalls and rare resets.
        stall_pct  = 25;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (fq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(i, ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)));
            end
            drive_req();
            cycle();
        end
        reset = 1'b0;
        drive_req();
        drain("random", 3000, n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_broadcast_inject_arbiter.md
Name: bsg_wormhole_broadcast_inject_arbiter

Overview:
- Shares the single input of one 1-D wormhole broadcast network between num_in_p injecting requesters.
- Arbitration is packet-granular and round-robin. A grant is decided only on a header flit, then held until the packet's last flit transfers, so flits from different packets never interleave.
- Sits directly upstream of the broadcast node input. Flit format is the network's: coordinate in bits [cord_width_p-1:0], payload length in [cord_width_p+:len_width_p].

Parameters:
- flit_width_p, none (required), flit width in bits.
- len_width_p, none (required), width of the header length field (number of body flits after the header).
- cord_width_p, none (required), width of the header coordinate field.
- num_in_p, 4, number of requesters (at least 2).

Ports:
- clk_i  input  1  clock; the block uses this one clock only.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  num_in_p  per-requester flit valid.
- data_i  input  num_in_p x flit_width_p  per-requester flit.
- ready_and_o  output  num_in_p  per-requester ready (valid-and-ready handshake).
- v_o  output  1  flit valid toward the broadcast input.
- data_o  output  flit_width_p  flit toward the broadcast input.
- ready_and_i  input  1  broadcast input ready.

Behaviour:
- A transfer occurs on output when v_o & ready_and_i, and on input i when v_i[i] & ready_and_o[i]. The two always coincide for the selected input.
- Zero-latency pass-through of the selected input:
  - v_o = v_i[sel]
  - data_o = data_i[sel]
  - ready_and_o = one-hot(sel) & {num_in_p{ready_and_i}}
  - ready_and_o is 0 for every input other than sel.
- State machine has two states, IDLE and LOCKED. Registers:
  - state
  - rr_ptr (index of highest-priority requester)
  - lock_idx
  - remain_r (len_width_p bits)
- IDLE:
  - sel = first i with v_i[i] set, scanning from rr_ptr upward with wrap-around.
  - If no v_i is set: v_o = 0 and ready_and_o = 0.
- On a header transfer in IDLE:
  - Header len == 0 (single-flit packet): stay in IDLE; rr_ptr <= sel+1 (mod num_in_p).
  - Header len > 0: lock_idx <= sel; remain_r <= len; go to LOCKED.
- LOCKED:
  - sel = lock_idx; other requesters are ignored even if valid.
  - Each transfer decrements remain_r.
  - The transfer with remain_r == 1 returns to IDLE and sets rr_ptr <= lock_idx+1 (mod num_in_p).
  - A stall (v_i[lock_idx] low or ready_and_i low) holds all state.
- In IDLE, a header that waits on ready_and_i low may be re-selected in a later cycle. Sel is not sticky until the header transfers.
- Maximum len (all ones) gives 2^len_width_p - 1 body flits. No overflow, because remain_r only decrements.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,num_in_p-1,0.
- Reset, applied at any time including mid-packet:
  - state = IDLE, rr_ptr = 0, lock_idx = 0, remain_r = 0.
  - v_o = 0 and ready_and_o = 0 throughout reset.
  - A partially sent packet is abandoned. Requesters and the network are reset together.
- Requester obligations: a requester must not withdraw v_i mid-packet except for a stall, and must not alter a header once presented.

Optional Feature:
- BSG_WORMHOLE_BCAST_ARB_ASSERT_EN
- When defined, simulation-only checks report an error if:
  - v_i[i] & ~ready_and_o[i] and data_i[i] changes the next cycle;
  - v_i[i] drops before the handshake;
  - v_o asserts while state == LOCKED and sel != lock_idx;
  - remain_r underflows.
- When undefined: no checks and identical RTL behaviour.

Decomposition:
- Package bsg_wormhole_broadcast_arb_pkg holds:
  - state enum (e_idle, e_locked);
  - parameterised header field extraction as localparam offsets for cord and len.
- Sub-module bsg_wormhole_broadcast_rr_picker: combinational rotate-priority picker taking v_i and rr_ptr and returning sel plus a found flag. It is reused for IDLE selection.

Test Plan (num_in_p=4, cord_width_p=4, len_width_p=4, flit_width_p=16; ready_and_i=1 unless noted):
- Reset, then v_i=4'b0000 -> v_o=0 and ready_and_o=0 for 3 cycles.
- Inputs 1 and 3 each present a header with len=2 in the same cycle, rr_ptr=0 -> input 1's 3 flits appear back-to-back; input 3's header follows in cycle 4; rr_ptr ends at 0 (3+1 mod 4).
- All four inputs continuously send len=0 headers -> grant order 0,1,2,3,0 on consecutive cycles; one flit per cycle.
- Input 2 sends len=3, ready_and_i=0 on its 2nd body flit for 2 cycles -> remain_r holds at 2; input 0 stays blocked despite v_i[0]=1; packet completes; input 0 is granted next.
- reset_i asserted for 1 cycle while LOCKED with remain_r=5 -> next cycle state=IDLE, rr_ptr=0, and a new header from input 0 is accepted.
- Header with len=15 (maximum) -> exactly 16 flits transfer, then the block returns to IDLE.
